// File: rtl/slow_clock_monitor_if.sv
// Divided-clock monitor bus: the slow clock/strobe in, edge enables and period/stall status out.
// master = divider/consumer side, slave = the monitor itself.
interface slow_clock_monitor_if #(
   parameter int CW = 24
);
   logic          slow_in;
   logic          rise_tick;
   logic          fall_tick;
   logic [CW-1:0] period;
   logic          period_valid;
   logic          stalled;
   logic [15:0]   rise_count;

   modport master (
      output slow_in,
      input  rise_tick, fall_tick, period, period_valid, stalled, rise_count
   );

   modport slave (
      input  slow_in,
      output rise_tick, fall_tick, period, period_valid, stalled, rise_count
   );
endinterface

// File: rtl/slow_clock_monitor.sv
// Turns a divided clock/strobe into clk-domain enables, measures its period and detects stalls.
// Define SLOW_CLOCK_MONITOR_FALL_TICK_EN to generate the falling-edge enable (fall_tick).
module slow_clock_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CW          = 24,
   parameter int TIMEOUT     = 10_000_000
) (
   input  logic                clk,
   input  logic                reset,
   slow_clock_monitor_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   prev_p1;
   logic                   sync;
   logic                   rise;
   logic [CW-1:0]          cnt;
   state_t                 state;

   assign sync = sync_p0[SYNC_STAGES-1];
   assign rise = sync & ~prev_p1;

   // Synchroniser + edge detect feed a single control FSM; all outputs are flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0          <= '0;
         prev_p1          <= 1'b0;
         cnt              <= '0;
         state            <= IDLE;
         bus.rise_tick    <= 1'b0;
         bus.period       <= '0;
         bus.period_valid <= 1'b0;
         bus.stalled      <= 1'b0;
         bus.rise_count   <= '0;
      end else begin
         sync_p0       <= {sync_p0[SYNC_STAGES-2:0], bus.slow_in};
         prev_p1       <= sync;
         bus.rise_tick <= rise;

         if (rise) begin
            cnt            <= CW'(1);
            bus.rise_count <= bus.rise_count + 16'd1;
         end else begin
            cnt <= sat_inc(cnt);
         end

         case (state)
            IDLE: begin
               if (rise)
                  state <= RUN;
            end
            RUN: begin
               // A rise landing on the timeout cycle is a valid measurement, not a stall.
               if (rise) begin
                  bus.period       <= cnt;
                  bus.period_valid <= 1'b1;
               end else if (cnt == TIMEOUT_C) begin
                  state            <= STALL;
                  bus.stalled      <= 1'b1;
                  bus.period_valid <= 1'b0;
               end
            end
            STALL: begin
               // First rise after a stall only re-arms the period counter.
               if (rise) begin
                  state       <= RUN;
                  bus.stalled <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SLOW_CLOCK_MONITOR_FALL_TICK_EN
   logic fall;
   assign fall = ~sync & prev_p1;

   always_ff @(posedge clk) begin
      if (reset)
         bus.fall_tick <= 1'b0;
      else
         bus.fall_tick <= fall;
   end
`else
   assign bus.fall_tick = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Scoreboard bench for slow_clock_monitor (SYNC_STAGES=2, CW=8, TIMEOUT=20).
// Stimulus pushes hand-computed expectations; a negedge monitor pops them as events appear.
module tb_slow_clock_monitor;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   fall_seen = 0;
   logic stalled_d = 1'b0;

   typedef struct {
      int          cyc;
      logic [7:0]  period;
      logic        valid;
      logic [15:0] count;
   } rise_t;

   typedef struct {
      int         cyc;
      logic [7:0] period;
   } stall_t;

   rise_t  rise_q[$];
   stall_t stall_q[$];
   int     fall_q[$];

   slow_clock_monitor_if #(.CW(8)) bus ();

   slow_clock_monitor #(
      .SYNC_STAGES(2),
      .CW(8),
      .TIMEOUT(20)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one high/low period. The first sampling edge is cyc+1, so ticks appear at cyc+3.
   task automatic pulse(input int hi, input int lo, input logic [7:0] ep, input logic ev,
                        input logic [15:0] ec, input bit exp_stall);
      rise_t  r;
      stall_t s;
      r.cyc = cyc + 3; r.period = ep; r.valid = ev; r.count = ec;
      rise_q.push_back(r);
      if (exp_stall) begin
         s.cyc = cyc + 3 + 20; s.period = ep;
         stall_q.push_back(s);
      end
      bus.slow_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1;
`ifdef SLOW_CLOCK_MONITOR_FALL_TICK_EN
      fall_q.push_back(cyc + 3);
`endif
      bus.slow_in = 1'b0;
      repeat (lo) @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rise_tick"},    32'(bus.rise_tick),    32'd0);
      chk({tag, "_fall_tick"},    32'(bus.fall_tick),    32'd0);
      chk({tag, "_period"},       32'(bus.period),       32'd0);
      chk({tag, "_period_valid"}, 32'(bus.period_valid), 32'd0);
      chk({tag, "_stalled"},      32'(bus.stalled),      32'd0);
      chk({tag, "_rise_count"},   32'(bus.rise_count),   32'd0);
   endtask

   // Monitor: pops the matching expectation whenever the DUT presents an event.
   always @(negedge clk) begin
      if (bus.rise_tick === 1'b1) begin
         if (rise_q.size() == 0) begin
            chk("rise_unexpected", 32'd1, 32'd0);
         end else begin
            rise_t e;
            e = rise_q.pop_front();
            chk("rise_cycle",        32'(cyc),              32'(e.cyc));
            chk("rise_period",       32'(bus.period),       32'(e.period));
            chk("rise_period_valid", 32'(bus.period_valid), 32'(e.valid));
            chk("rise_stalled",      32'(bus.stalled),      32'd0);
            chk("rise_count",        32'(bus.rise_count),   32'(e.count));
         end
      end
      if (bus.stalled === 1'b1 && !stalled_d) begin
         if (stall_q.size() == 0) begin
            chk("stall_unexpected", 32'd1, 32'd0);
         end else begin
            stall_t s;
            s = stall_q.pop_front();
            chk("stall_cycle",        32'(cyc),              32'(s.cyc));
            chk("stall_period_valid", 32'(bus.period_valid), 32'd0);
            chk("stall_period_hold",  32'(bus.period),       32'(s.period));
         end
      end
      stalled_d = (bus.stalled === 1'b1);
      if (bus.fall_tick === 1'b1) begin
`ifdef SLOW_CLOCK_MONITOR_FALL_TICK_EN
         if (fall_q.size() == 0) begin
            chk("fall_unexpected", 32'd1, 32'd0);
         end else begin
            chk("fall_cycle", 32'(cyc), 32'(fall_q.pop_front()));
         end
`else
         fall_seen++;
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      bus.slow_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // Test 1: reset with slow_in high, then a single rise from IDLE
      chk_all_zero("reset_init");
      reset = 1'b0;
      pulse(5, 5, 8'd0, 1'b0, 16'd1, 1'b0);

      // Test 2: 5/5 square wave
      pulse(5, 5, 8'd10, 1'b1, 16'd2, 1'b0);
      pulse(5, 5, 8'd10, 1'b1, 16'd3, 1'b0);
      pulse(5, 5, 8'd10, 1'b1, 16'd4, 1'b0);

      // Test 3: stall, recovery rise, then a 7-cycle period
      pulse(5, 30, 8'd10, 1'b1, 16'd5, 1'b1);
      pulse(4, 3,  8'd10, 1'b0, 16'd6, 1'b0);
      pulse(5, 15, 8'd7,  1'b1, 16'd7, 1'b0);

      // Test 4: rise exactly on the timeout cycle
      pulse(5, 5, 8'd20, 1'b1, 16'd8, 1'b0);

      // Test 5: reset while a valid 10-cycle period is held
      pulse(5, 5, 8'd10, 1'b1, 16'd9, 1'b0);
      chk("pre_reset_period",       32'(bus.period),       32'd10);
      chk("pre_reset_period_valid", 32'(bus.period_valid), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("reset_mid");
      reset = 1'b0;
      pulse(5, 5, 8'd0,  1'b0, 16'd1, 1'b0);
      pulse(5, 5, 8'd10, 1'b1, 16'd2, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      chk("rise_queue_drained",  32'(rise_q.size()),  32'd0);
      chk("stall_queue_drained", 32'(stall_q.size()), 32'd0);
      chk("fall_queue_drained",  32'(fall_q.size()),  32'd0);
      chk("fall_never_when_disabled", 32'(fall_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
